// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780 8-bit mode power-up init plus button-driven write
// cycles (letter, word space, clear, completion) with 16x2 cursor wrap.
module lcd_sequencer #(
  parameter int E_PULSE_CYC    = 50,
  parameter int CMD_WAIT_CYC   = 5000,
  parameter int CLR_WAIT_CYC   = 200000,
  parameter int PWRUP_WAIT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       enter_letter,
  input  logic       finish_word,
  input  logic       clear_display,
  input  logic       complete_input,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy,
  output logic       done,
  output logic [4:0] pos
);

  // INIT and ADDR double as the one-cycle setup phase of their own command.
  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ADDR
  } state_t;

  // What the write currently in flight is for; decides where HOLD exits to.
  typedef enum logic [1:0] {K_INIT, K_ADDR, K_DATA, K_CLEAR} kind_t;

  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_WAIT_CYC - 1);
  localparam logic [31:0] E_LAST     = 32'(E_PULSE_CYC - 1);
  localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT_CYC - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT_CYC - 1);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        e_q, e_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  pos_q, pos_d;
  logic        wrap_q, wrap_d;
  logic [3:0]  prev_q, prev_d;

  logic [3:0]  btn;
  logic [3:0]  rise;
  logic [31:0] hold_last;
  logic [7:0]  wr_byte;

  // Bit order encodes priority: clear, complete, letter, word.
  assign btn  = {clear_display, complete_input, enter_letter, finish_word};
  assign rise = btn & ~prev_q;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  // Next-state logic; registered outputs are derived from the next state.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = cnt_q + 32'd1;
    init_idx_d = init_idx_q;
    pend_d     = pend_q;
    data_d     = data_q;
    rs_d       = rs_q;
    done_d     = done_q;
    pos_d      = pos_q;
    wrap_d     = wrap_q;
    prev_d     = btn;
    wr_byte    = rise[1] ? char_in : 8'h20;
    hold_last  = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWRUP_LAST) begin
          state_d    = S_INIT;
          cnt_d      = '0;
          kind_d     = K_INIT;
          init_idx_d = 2'd0;
          data_d     = init_cmd(2'd0);
          rs_d       = 1'b0;
        end
      end
      S_INIT, S_SETUP, S_ADDR: begin
        state_d = S_STROBE;
        cnt_d   = '0;
      end
      S_STROBE: begin
        if (cnt_q == E_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == hold_last) begin
          cnt_d = '0;
          case (kind_q)
            K_INIT: begin
              if (init_idx_q == 2'd3) begin
                state_d = S_IDLE;
              end else begin
                state_d    = S_INIT;
                init_idx_d = init_idx_q + 2'd1;
                data_d     = init_cmd(init_idx_q + 2'd1);
              end
            end
            K_ADDR: begin
              state_d = S_SETUP;
              kind_d  = K_DATA;
              data_d  = pend_q;
              rs_d    = 1'b1;
            end
            K_DATA: begin
              state_d = S_IDLE;
              pos_d   = pos_q + 5'd1;
              if (pos_q == 5'd31) wrap_d = 1'b1;
            end
            default: begin
              state_d = S_IDLE;
              pos_d   = '0;
              done_d  = 1'b0;
              wrap_d  = 1'b0;
            end
          endcase
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (rise[3]) begin
          state_d = S_SETUP;
          kind_d  = K_CLEAR;
          data_d  = 8'h01;
          rs_d    = 1'b0;
        end else if (rise[2]) begin
          done_d = 1'b1;
        end else if ((rise[1] || rise[0]) && !done_q) begin
          if (pos_q == 5'd16 || (wrap_q && pos_q == 5'd0)) begin
            // Cursor must be repositioned before this character lands.
            state_d = S_ADDR;
            kind_d  = K_ADDR;
            pend_d  = wr_byte;
            data_d  = (pos_q == 5'd16) ? 8'hC0 : 8'h80;
            rs_d    = 1'b0;
          end else begin
            state_d = S_SETUP;
            kind_d  = K_DATA;
            data_d  = wr_byte;
            rs_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase

    e_d    = (state_d == S_STROBE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; previous-button flops reset high so held
  // buttons produce no edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PWRUP;
      kind_q     <= K_INIT;
      cnt_q      <= '0;
      init_idx_q <= '0;
      pend_q     <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      e_q        <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      pos_q      <= '0;
      wrap_q     <= 1'b0;
      prev_q     <= 4'hF;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      init_idx_q <= init_idx_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      e_q        <= e_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pos_q      <= pos_d;
      wrap_q     <= wrap_d;
      prev_q     <= prev_d;
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pos      = pos_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Testbench for lcd_sequencer: scoreboard of expected LCD writes checked on
// every E rising edge, plus per-scenario busy/pos/done checks.
module tb_lcd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       enter_letter = 1'b0;
  logic       finish_word = 1'b0;
  logic       clear_display = 1'b0;
  logic       complete_input = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e, busy, done;
  logic [4:0] pos;

  int total = 0;
  int bad   = 0;

  typedef logic [8:0] exp_t;  // {rs, data}
  exp_t sb[$];

  int   mpos  = 0;
  bit   mwrap = 1'b0;
  bit   ignore_width = 1'b0;
  logic e_prev = 1'b0;
  int   e_len = 0;

  localparam logic [3:0] M_CLEAR = 4'b1000;
  localparam logic [3:0] M_DONE  = 4'b0100;
  localparam logic [3:0] M_LET   = 4'b0010;
  localparam logic [3:0] M_WORD  = 4'b0001;

  lcd_sequencer #(
    .E_PULSE_CYC(2), .CMD_WAIT_CYC(4), .CLR_WAIT_CYC(10), .PWRUP_WAIT_CYC(20)
  ) dut (
    .clk(clk), .rst(rst), .char_in(char_in),
    .enter_letter(enter_letter), .finish_word(finish_word),
    .clear_display(clear_display), .complete_input(complete_input),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .busy(busy), .done(done), .pos(pos)
  );

  always #5 clk = ~clk;

  // Monitor: pop and compare on each E rise, check pulse width on each fall.
  always @(negedge clk) begin : monitor
    exp_t ex;
    if (lcd_e && !e_prev) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got rs=%0b data=%02h, required no write", lcd_rs, lcd_data);
      end else begin
        ex = sb.pop_front();
        if ({lcd_rs, lcd_data} !== ex) begin
          bad++;
          $display("FAIL write_value: got rs=%0b data=%02h, required rs=%0b data=%02h",
                   lcd_rs, lcd_data, ex[8], ex[7:0]);
        end else begin
          $display("write rs=%0b data=%02h", lcd_rs, lcd_data);
        end
      end
      e_len = 1;
    end else if (lcd_e) begin
      e_len++;
    end
    if (!lcd_e && e_prev && !ignore_width) begin
      total++;
      if (e_len !== 2) begin
        bad++;
        $display("FAIL e_width: got %0d, required 2", e_len);
      end
    end
    e_prev = lcd_e;
  end

  // Push the expected writes for one character; returns expected busy cycles.
  task automatic model_char(input logic [7:0] b, output int exp_busy);
    exp_busy = 7;
    if (mpos == 16) begin
      sb.push_back({1'b0, 8'hC0});
      exp_busy = 14;
    end else if (mwrap && mpos == 0) begin
      sb.push_back({1'b0, 8'h80});
      exp_busy = 14;
    end
    sb.push_back({1'b1, b});
    if (mpos == 31) mwrap = 1'b1;
    mpos = (mpos + 1) % 32;
  endtask

  // Raise the selected buttons for one event and count busy cycles.
  task automatic press(input logic [3:0] mask, output int nbusy);
    @(posedge clk); #1;
    {clear_display, complete_input, enter_letter, finish_word} = mask;
    nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    @(posedge clk); #1;
    {clear_display, complete_input, enter_letter, finish_word} = 4'b0000;
    repeat (2) @(posedge clk);
  endtask

  // Release rst and time the PWRUP + INIT sequence.
  task automatic release_and_init(input string tag);
    int n;
    sb.delete();
    sb.push_back({1'b0, 8'h38});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
    mpos = 0; mwrap = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    total++;
    if (n !== 54) begin bad++; $display("FAIL %s_init_time: got %0d cycles, required 54", tag, n); end
    else $display("%s init complete after %0d cycles", tag, n);
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL %s_init_writes: %0d writes missing, required 0", tag, sb.size()); end
    total++;
    if (pos !== 5'd0 || done !== 1'b0) begin
      bad++; $display("FAIL %s_idle_state: got pos=%0d done=%0b, required pos=0 done=0", tag, pos, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({lcd_e, lcd_rs, lcd_rw, busy, done} !== 5'b00010) begin
      bad++; $display("FAIL reset_ctrl: got e=%0b rs=%0b rw=%0b busy=%0b done=%0b, required 0 0 0 1 0",
                      lcd_e, lcd_rs, lcd_rw, busy, done);
    end
    total++;
    if (lcd_data !== 8'h00 || pos !== 5'd0) begin
      bad++; $display("FAIL reset_data: got data=%02h pos=%0d, required 00 0", lcd_data, pos);
    end
    release_and_init("reset");
  endtask

  task automatic test_letter();
    int eb, nb;
    char_in = 8'h41;
    model_char(8'h41, eb);
    press(M_LET, nb);
    total++;
    if (nb !== 7) begin bad++; $display("FAIL letter_busy: got %0d, required 7", nb); end
    total++;
    if (pos !== 5'd1) begin bad++; $display("FAIL letter_pos: got %0d, required 1", pos); end
    $display("letter A busy=%0d pos=%0d", nb, pos);
  endtask

  task automatic test_line_wrap();
    int eb, nb;
    sb.push_back({1'b0, 8'h01});
    press(M_CLEAR, nb);
    mpos = 0; mwrap = 1'b0;
    total++;
    if (nb !== 13) begin bad++; $display("FAIL clear_busy: got %0d, required 13", nb); end
    for (int i = 0; i < 16; i++) begin
      char_in = 8'h61 + 8'(i);
      model_char(char_in, eb);
      press(M_LET, nb);
      total++;
      if (nb !== eb) begin bad++; $display("FAIL line0_busy[%0d]: got %0d, required %0d", i, nb, eb); end
    end
    model_char(8'h20, eb);
    press(M_WORD, nb);
    total++;
    if (nb !== 14) begin bad++; $display("FAIL word_busy: got %0d, required 14", nb); end
    total++;
    if (pos !== 5'd17) begin bad++; $display("FAIL word_pos: got %0d, required 17", pos); end
    $display("word at line 1 busy=%0d pos=%0d", nb, pos);
  endtask

  task automatic test_screen_wrap();
    int eb, nb;
    for (int i = 0; i < 15; i++) begin
      char_in = 8'h30 + 8'(i);
      model_char(char_in, eb);
      press(M_LET, nb);
      total++;
      if (nb !== eb) begin bad++; $display("FAIL line1_busy[%0d]: got %0d, required %0d", i, nb, eb); end
    end
    total++;
    if (pos !== 5'd0) begin bad++; $display("FAIL wrap_pos: got %0d, required 0", pos); end
    char_in = 8'h5A;
    model_char(8'h5A, eb);
    press(M_LET, nb);
    total++;
    if (nb !== 14) begin bad++; $display("FAIL wrap_busy: got %0d, required 14", nb); end
    total++;
    if (pos !== 5'd1) begin bad++; $display("FAIL wrap_end_pos: got %0d, required 1", pos); end
    $display("33rd char busy=%0d pos=%0d", nb, pos);
  endtask

  task automatic test_simultaneous();
    int nb;
    char_in = 8'h42;
    sb.push_back({1'b0, 8'h01});
    press(M_CLEAR | M_LET, nb);
    mpos = 0; mwrap = 1'b0;
    total++;
    if (nb !== 13) begin bad++; $display("FAIL simul_busy: got %0d, required 13", nb); end
    total++;
    if (pos !== 5'd0) begin bad++; $display("FAIL simul_pos: got %0d, required 0", pos); end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL simul_writes: %0d pending, required 0", sb.size()); end
    $display("clear+letter busy=%0d pos=%0d", nb, pos);
  endtask

  task automatic test_completion();
    int nb;
    @(posedge clk); #1 complete_input = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_early: got %0b, required 0", done); end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL done_set: got done=%0b busy=%0b, required 1 0", done, busy);
    end
    @(posedge clk); #1 complete_input = 1'b0;
    char_in = 8'h43;
    press(M_LET, nb);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL done_ignore_busy: got %0d, required 0", nb); end
    total++;
    if (pos !== 5'd0 || done !== 1'b1) begin
      bad++; $display("FAIL done_ignore_state: got pos=%0d done=%0b, required 0 1", pos, done);
    end
    sb.push_back({1'b0, 8'h01});
    press(M_CLEAR, nb);
    total++;
    if (done !== 1'b0 || nb !== 13) begin
      bad++; $display("FAIL done_clear: got done=%0b busy=%0d, required 0 13", done, nb);
    end
    $display("completion: done cleared, busy=%0d", nb);
  endtask

  task automatic test_reset_midwrite();
    int  k;
    bit  seen;
    char_in = 8'h5A;
    sb.push_back({1'b1, 8'h5A});
    @(posedge clk); #1 enter_letter = 1'b1;
    seen = 1'b0;
    k = 0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      if (lcd_e) seen = 1'b1;
      k++;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL midrst_strobe: got no E pulse, required one within 20 cycles"); end
    ignore_width = 1'b1;
    rst = 1'b1;
    enter_letter = 1'b0;
    @(negedge clk);
    total++;
    if (lcd_e !== 1'b0 || busy !== 1'b1 || pos !== 5'd0) begin
      bad++; $display("FAIL midrst_e: got e=%0b busy=%0b pos=%0d, required 0 1 0", lcd_e, busy, pos);
    end
    release_and_init("midrst");
    ignore_width = 1'b0;
  endtask

  initial begin
    test_reset();
    test_letter();
    test_line_wrap();
    test_screen_wrap();
    test_simultaneous();
    test_completion();
    test_reset_midwrite();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
